// File: rtl/extend_pipe.sv
// Immediate extender with a 2-entry {result, tag} output buffer and valid/ready handshakes.
// Define EXTEND_PIPE_STATS_EN to add the saturating 16-bit xfer_count output.
module extend_pipe #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_mode,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef EXTEND_PIPE_STATS_EN
  ,
  output logic [15:0]      xfer_count
`endif
);

  localparam int EXT_W = OUT_W - IN_W;

  logic [OUT_W-1:0] sign_ext;
  logic [OUT_W-1:0] ext_result;

  logic [OUT_W-1:0] data_q [2];
  logic [TAG_W-1:0] tag_q  [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;
  logic             push, pop;

  always_comb begin
    sign_ext = {{EXT_W{in_imm[IN_W-1]}}, in_imm};
    ext_result = sign_ext;
    case (in_mode)
      2'b00: ext_result = sign_ext;
      2'b01: ext_result = {{EXT_W{1'b0}}, in_imm};
      2'b10: ext_result = {in_imm, {EXT_W{1'b0}}};
      2'b11: ext_result = {sign_ext[OUT_W-3:0], 2'b00};
      default: ext_result = sign_ext;
    endcase
  end

  // Handshake flags come only from registered occupancy, so in_ready never sees out_ready.
  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_data = data_q[rd_ptr_q];
  assign out_tag  = tag_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  // Storage is cleared on reset so out_data/out_tag read as zero afterwards.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      count_q   <= 2'd0;
      data_q[0] <= '0;
      data_q[1] <= '0;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        data_q[wr_ptr_q] <= ext_result;
        tag_q[wr_ptr_q]  <= in_tag;
      end
    end
  end

`ifdef EXTEND_PIPE_STATS_EN
  logic [15:0] xfer_count_q, xfer_count_d;

  always_comb begin
    xfer_count_d = xfer_count_q;
    if (pop && (xfer_count_q != 16'hFFFF)) begin
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xfer_count_q <= 16'd0;
    end else begin
      xfer_count_q <= xfer_count_d;
    end
  end

  assign xfer_count = xfer_count_q;
`endif

endmodule

// File: tb/tb_extend_pipe.sv
// Scoreboard bench for extend_pipe: driver pushes expected {data, tag} on acceptance,
// an independent monitor checks occupancy flags and the buffer head every cycle.
module tb_extend_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_mode;
  logic [15:0] in_imm;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
`ifdef EXTEND_PIPE_STATS_EN
  logic [15:0] xfer_count;
`endif

  int total = 0;
  int bad = 0;
  int popCount = 0;
  bit monitorOn = 0;
  logic [36:0] sb [$];

  extend_pipe #(.IN_W(16), .OUT_W(32), .TAG_W(5)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_mode(in_mode),
    .in_imm(in_imm),
    .in_tag(in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_tag(out_tag)
`ifdef EXTEND_PIPE_STATS_EN
    ,
    .xfer_count(xfer_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  // Reference extension computed arithmetically from the mode rules.
  function automatic logic [31:0] refExtend(input logic [1:0] m, input logic [15:0] imm);
    longint s;
    longint v;
    s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
    case (m)
      2'd0: v = s;
      2'd1: v = longint'(imm);
      2'd2: v = longint'(imm) * 65536;
      default: v = s * 4;
    endcase
    return 32'(v & 64'hFFFF_FFFF);
  endfunction

  // Monitor: at negedge+1 the registered outputs reflect the model occupancy.
  initial begin
    logic [36:0] head;
    forever begin
      @(negedge clk);
      #1;
      if (monitorOn && rst_n) begin
        checkOutput("inReady", in_ready, sb.size() != 2);
        checkOutput("outValid", out_valid, sb.size() != 0);
`ifdef EXTEND_PIPE_STATS_EN
        checkOutput("xferCount", xfer_count, popCount);
`endif
        if (out_valid && sb.size() != 0) begin
          head = sb[0];
          checkOutput("outData", out_data, head[36:5]);
          checkOutput("outTag", out_tag, head[4:0]);
          if (out_ready) begin
            void'(sb.pop_front());
            popCount++;
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] m, input logic [15:0] imm, input logic [4:0] tg,
                               input logic [31:0] expected);
    int waited;
    bit taken;
    waited = 0;
    taken = 0;
    in_valid = 1'b1;
    in_mode = m;
    in_imm = imm;
    in_tag = tg;
    while (!taken && waited < 100) begin
      #2;
      if (in_ready) begin
        sb.push_back({expected, tg});
        taken = 1;
      end
      @(negedge clk);
      waited++;
    end
    in_valid = 1'b0;
    if (!taken) checkOutput("acceptTimeout", 0, 1);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [15:0] imm;
    logic [1:0] m;
    logic [4:0] tg;
    int drainWait;

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_mode = 2'd0;
    in_imm = 16'd0;
    in_tag = 5'd0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    monitorOn = 1;
    #2;
    checkOutput("rstOutData", out_data, 32'h0);
    checkOutput("rstOutTag", out_tag, 5'd0);
    @(negedge clk);

    // Directed extension modes with the consumer always ready.
    out_ready = 1'b1;
    applyStimulus(2'b00, 16'h8001, 5'd3, 32'hFFFF_8001);
    applyStimulus(2'b01, 16'h8001, 5'd4, 32'h0000_8001);
    applyStimulus(2'b10, 16'h1234, 5'd5, 32'h1234_0000);
    applyStimulus(2'b11, 16'hFFFF, 5'd6, 32'hFFFF_FFFC);
    applyStimulus(2'b11, 16'h0004, 5'd7, 32'h0000_0010);
    idleCycles(3);

    // Backpressure: A and B fill the buffer, C must wait until a slot frees.
    out_ready = 1'b0;
    applyStimulus(2'b01, 16'h00AA, 5'd10, 32'h0000_00AA);
    applyStimulus(2'b01, 16'h00BB, 5'd11, 32'h0000_00BB);
    in_valid = 1'b1;
    in_mode = 2'b01;
    in_imm = 16'h00CC;
    in_tag = 5'd12;
    #2;
    checkOutput("cHeldOff0", in_ready, 1'b0);
    @(negedge clk);
    #2;
    checkOutput("cHeldOff1", in_ready, 1'b0);
    @(negedge clk);
    out_ready = 1'b1;
    #2;
    checkOutput("fullPopReady", in_ready, 1'b0);
    @(negedge clk);
    applyStimulus(2'b01, 16'h00CC, 5'd12, 32'h0000_00CC);
    idleCycles(4);

    // Reset while full; the transfer offered during reset must vanish.
    out_ready = 1'b0;
    applyStimulus(2'b00, 16'h7FFF, 5'd20, refExtend(2'b00, 16'h7FFF));
    applyStimulus(2'b10, 16'hFFFF, 5'd21, refExtend(2'b10, 16'hFFFF));
    rst_n = 1'b0;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    popCount = 0;
    #2;
    checkOutput("postRstOutValid", out_valid, 1'b0);
    checkOutput("postRstInReady", in_ready, 1'b1);
    checkOutput("postRstOutData", out_data, 32'h0);
    checkOutput("postRstOutTag", out_tag, 5'd0);
`ifdef EXTEND_PIPE_STATS_EN
    checkOutput("postRstXfer", xfer_count, 16'd0);
`endif
    @(negedge clk);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom_range(3) != 0);
      m = 2'($urandom_range(3));
      tg = 5'($urandom_range(31));
      case ($urandom_range(7))
        0: imm = 16'h0000;
        1: imm = 16'h7FFF;
        2: imm = 16'h8000;
        3: imm = 16'hFFFF;
        default: imm = 16'($urandom_range(65535));
      endcase
      in_valid = ($urandom_range(1) != 0);
      in_mode = m;
      in_imm = imm;
      in_tag = tg;
      #2;
      if (in_valid && in_ready) sb.push_back({refExtend(m, imm), tg});
      @(negedge clk);
    end
    in_valid = 1'b0;

    out_ready = 1'b1;
    drainWait = 0;
    while (sb.size() != 0 && drainWait < 10) begin
      @(negedge clk);
      drainWait++;
    end
    checkOutput("drainEmpty", sb.size(), 0);
    idleCycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/extend_pipe.md
EXTEND_PIPE -- requirements
Module: extend_pipe

Interface
REQ-001 Parameter IN_W, default 16: immediate input width in bits.
REQ-002 Parameter OUT_W, default 32: extended output width in bits; OUT_W > IN_W+2 required.
REQ-003 Parameter TAG_W, default 5: width of the sideband tag carried with each immediate.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  producer offers an immediate this cycle.
REQ-007 in_ready  output  1  block can accept an immediate this cycle.
REQ-008 in_mode  input  2  extension mode: 00 sign, 01 zero, 10 upper, 11 sign-shift2.
REQ-009 in_imm  input  IN_W  raw immediate.
REQ-010 in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-011 out_valid  output  1  result available at the head of the buffer.
REQ-012 out_ready  input  1  consumer takes the result this cycle.
REQ-013 out_data  output  OUT_W  extended result.
REQ-014 out_tag  output  TAG_W  tag paired with out_data.

Function
REQ-015 Mode 00 SHALL replicate in_imm[IN_W-1] into the upper OUT_W-IN_W bits.
REQ-016 Mode 01 SHALL fill the upper OUT_W-IN_W bits with zeros.
REQ-017 Mode 10 SHALL place in_imm in the upper IN_W bits and fill the lower OUT_W-IN_W bits with zeros.
REQ-018 Mode 11 SHALL sign-extend as in mode 00, then shift left by 2, discarding the top 2 bits and filling bits [1:0] with zeros.
REQ-019 The input transfer SHALL occur on a rising edge where in_valid and in_ready are both 1; the output transfer SHALL occur where out_valid and out_ready are both 1.
REQ-020 The block SHALL hold a 2-entry FIFO of {result, tag}; the result is computed at acceptance and stored.
REQ-021 Latency: an immediate accepted at edge N into an empty buffer SHALL appear with out_valid=1 from edge N until it is popped.
REQ-022 in_ready SHALL equal (occupancy != 2) and depend only on registered state, never combinationally on out_ready.
REQ-023 When occupancy is 2 and a pop occurs, in_ready SHALL remain 0 that cycle and rise to 1 after the edge.
REQ-024 A push and a pop in the same cycle at occupancy 1 SHALL leave occupancy at 1 and advance the head.
REQ-025 out_valid SHALL equal (occupancy != 0); out_data and out_tag SHALL remain stable while out_valid=1 and out_ready=0.
REQ-026 Results SHALL emerge in acceptance order; no entry is dropped or duplicated.
REQ-027 in_valid while in_ready=0 SHALL be ignored with no state change.
REQ-028 Read and write pointers SHALL be 1 bit each and wrap from 1 to 0.

Reset
REQ-029 With rst_n=0 at a rising edge, occupancy and both pointers SHALL clear to 0, discarding any buffered entries.
REQ-030 After that reset edge: out_valid=0, in_ready=1; out_data and out_tag SHALL be 0.
REQ-031 A transfer presented during a reset cycle SHALL be neither accepted nor delivered.

Configuration
REQ-032 Macro EXTEND_PIPE_STATS_EN defined: a 16-bit output xfer_count SHALL count output transfers, saturate at 0xFFFF, and reset to 0.
REQ-033 EXTEND_PIPE_STATS_EN undefined: port xfer_count and its counter SHALL be absent, with all other behaviour unchanged.

Verification (IN_W=16, OUT_W=32)
REQ-034 Test mode 00: input imm 0x8001, tag 3, out_ready=1 -> next cycle out_valid=1, out_data 0xFFFF8001, out_tag 3.
REQ-035 Test modes 01/10: mode 01 imm 0x8001 -> 0x00008001; mode 10 imm 0x1234 -> 0x12340000.
REQ-036 Test mode 11: imm 0xFFFF -> 0xFFFFFFFC; imm 0x0004 -> 0x00000010.
REQ-037 Test backpressure: with out_ready=0, offer A,B,C back-to-back -> A,B accepted, in_ready=0 and C held off; raise out_ready -> A then B, then C accepted, order intact.
REQ-038 Test reset mid-operation: occupancy 2, rst_n=0 for one edge -> out_valid=0, in_ready=1, and xfer_count=0 if stats are enabled.
REQ-039 Test stats: with EXTEND_PIPE_STATS_EN, 5 output transfers -> xfer_count=5; preload/force to 0xFFFF plus one transfer -> stays 0xFFFF.
